// File: rtl/log2_approx_pipe_if.sv
// Stream bundle for log2_approx_pipe: input beat handshake and result beat handshake.
// The slave modport is the pipeline's view, and the master modport is the producer/consumer view.
interface log2_approx_pipe_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*OUT_W-1:0]  out_log;
  logic [LANES-1:0]        out_zero;
  logic [LANES*DATA_W-1:0] out_bypass;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_log, out_zero, out_bypass
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_log, out_zero, out_bypass
  );
endinterface

// File: rtl/log2_approx_pipe.sv
// Multi-lane log2(x) approximator: leading-one position plus linear mantissa fraction.
// The pipeline has three stages, a valid/ready handshake with backpressure, and a global freeze (i_en).
module log2_approx_pipe #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int OUT_W      = 16,
  parameter int OUT_FRAC_W = 8,
  parameter int LANES      = 2,
  parameter int ROUND      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  log2_approx_pipe_if.slave bus
);
  localparam int PW = $clog2(DATA_W);
  localparam int MW = DATA_W - 1;

  logic                         r_s1_valid;
  logic [LANES*DATA_W-1:0]      r_s1_data;
  logic                         r_s2_valid;
  logic [LANES*DATA_W-1:0]      r_s2_data;
  logic [LANES-1:0][PW-1:0]     r_s2_pos;
  logic [LANES-1:0]             r_s2_zero;
  logic                         r_s3_valid;
  logic [LANES*OUT_W-1:0]       r_s3_log;
  logic [LANES-1:0]             r_s3_zero;
  logic [LANES*DATA_W-1:0]      r_s3_data;

  logic                         w_ld1, w_ld2, w_ld3;
  logic [LANES-1:0][PW-1:0]     w_pos;
  logic [LANES-1:0]             w_zero;
  logic [LANES*OUT_W-1:0]       w_log;

  // A stage loads when it is empty or its content moves on; i_en gates the whole chain.
  assign w_ld3 = i_en & (~r_s3_valid | bus.out_ready);
  assign w_ld2 = i_en & (~r_s2_valid | w_ld3);
  assign w_ld1 = i_en & (~r_s1_valid | w_ld2);

  assign bus.in_ready   = w_ld1;
  assign bus.out_valid  = r_s3_valid;
  assign bus.out_log    = r_s3_log;
  assign bus.out_zero   = r_s3_zero;
  assign bus.out_bypass = r_s3_data;

  // NOTE: every combinational output gets a default before the loops, so no latch is inferred.
  always_comb begin
    w_pos  = '0;
    w_zero = '0;
    for (int l = 0; l < LANES; l++) begin
      w_zero[l] = (r_s1_data[l*DATA_W +: DATA_W] == '0);
      for (int b = 0; b < DATA_W; b++) begin
        if (r_s1_data[l*DATA_W + b]) w_pos[l] = PW'(b);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [MW-1:0]    w_norm;
    logic [OUT_W-1:0] w_mant;
    logic             w_rb;
    logic [OUT_W-1:0] w_sum;

    // Shift the leading one out of the word; the remaining bits are the left-aligned mantissa.
    assign w_norm = MW'(r_s2_data[g*DATA_W +: DATA_W] << (MW - int'(r_s2_pos[g])));

    if (OUT_FRAC_W >= MW) begin : g_pad
      assign w_mant = OUT_W'(w_norm) << (OUT_FRAC_W - MW);
      assign w_rb   = 1'b0;
    end else begin : g_cut
      assign w_mant = OUT_W'(w_norm >> (MW - OUT_FRAC_W));
      assign w_rb   = (ROUND != 0) & w_norm[MW - OUT_FRAC_W - 1];
    end

    // Adding the round bit across the whole word lets a mantissa carry ripple into the integer part.
    assign w_sum = OUT_W'(((int'(r_s2_pos[g]) - FRAC_W) <<< OUT_FRAC_W)
                          + int'(w_mant) + int'(w_rb));
    assign w_log[g*OUT_W +: OUT_W] = r_s2_zero[g] ? {1'b1, {(OUT_W-1){1'b0}}} : w_sum;
  end

  // NOTE: only the valids and the visible outputs take reset; interior datapath registers do not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_log   <= '0;
      r_s3_zero  <= '0;
      r_s3_data  <= '0;
    end else begin
      if (w_ld1) r_s1_valid <= bus.in_valid;
      if (w_ld2) r_s2_valid <= r_s1_valid;
      if (w_ld3) begin
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_s3_log  <= w_log;
          r_s3_zero <= r_s2_zero;
          r_s3_data <= r_s2_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld1 && bus.in_valid) r_s1_data <= bus.in_data;
    if (w_ld2 && r_s1_valid) begin
      r_s2_data <= r_s1_data;
      r_s2_pos  <= w_pos;
      r_s2_zero <= w_zero;
    end
  end
endmodule

// File: tb/tb_log2_approx_pipe.sv
// Self-checking bench for log2_approx_pipe: table vectors, handshake corner sequences and random traffic.
// Two instances run in lockstep, one truncating and one rounding, both fed the same stream.
module tb_log2_approx_pipe;
  logic clk;
  logic rst;
  logic en;

  log2_approx_pipe_if #(.LANES(2), .DATA_W(16), .OUT_W(16)) bus ();
  log2_approx_pipe_if #(.LANES(2), .DATA_W(16), .OUT_W(16)) bus_r ();

  assign bus_r.in_valid  = bus.in_valid;
  assign bus_r.in_data   = bus.in_data;
  assign bus_r.out_ready = bus.out_ready;

  log2_approx_pipe #(.ROUND(0)) dut   (.clk(clk), .rst(rst), .i_en(en), .bus(bus));
  log2_approx_pipe #(.ROUND(1)) dut_r (.clk(clk), .rst(rst), .i_en(en), .bus(bus_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [15:0] t0, t1, r0, r1;
    logic [1:0]  zero;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          out_cnt = 0;
  bit          chk_lat = 0;
  bit          rnd_done;
  beat_t       exp_q[$];
  logic [31:0] stim[512];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor(log2 x) for the integer part, then the linear fraction (x - 2^p) / 2^p scaled by 256.
  function automatic logic [15:0] ref_log(input logic [15:0] x, input bit rnd);
    int     p;
    longint a, m;
    if (x == 16'd0) return 16'h8000;
    p = 0;
    while ((int'(x) >> (p + 1)) != 0) p++;
    a = longint'(x) - (longint'(1) << p);
    if (rnd) m = ((a << 9) + (longint'(1) << p)) >> (p + 1);
    else     m = (a << 8) >> p;
    return 16'((p - 8) * 256 + int'(m));
  endfunction

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'(1 << $urandom_range(0, 15));
      2:       return 16'($urandom_range(1, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: every accepted beat must come out once, in order, with model-computed results.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!en) check("in_ready_frozen", bus.in_ready, 1'b0);
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{bus.in_data, cyc});
      if (en && bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.out_bypass, 32'h0);
          check("unexpected_valid", bus.out_valid, 1'b0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          for (int l = 0; l < 2; l++) begin
            check($sformatf("log_l%0d", l), bus.out_log[l*16 +: 16], ref_log(b.data[l*16 +: 16], 1'b0));
            check($sformatf("log_rnd_l%0d", l), bus_r.out_log[l*16 +: 16], ref_log(b.data[l*16 +: 16], 1'b1));
          end
          check("zero", bus.out_zero, {b.data[31:16] == 16'd0, b.data[15:0] == 16'd0});
          check("bypass", bus.out_bypass, b.data);
          check("rnd_valid", bus_r.out_valid, 1'b1);
          check("rnd_zero", bus_r.out_zero, {b.data[31:16] == 16'd0, b.data[15:0] == 16'd0});
          if (chk_lat) check("latency", cyc - b.cyc, 3);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_log"}, bus.out_log, 32'h0);
    check({tag, "_out_zero"}, bus.out_zero, 2'b00);
    check({tag, "_out_bypass"}, bus.out_bypass, 32'h0);
    check({tag, "_rnd_out_valid"}, bus_r.out_valid, 1'b0);
    check({tag, "_rnd_out_log"}, bus_r.out_log, 32'h0);
  endtask

  task automatic send_beats(input int n, input bit gaps);
    int tries;
    bit taken;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      tries = 0;
      taken = 1'b0;
      while (!taken && tries < 200) begin
        @(negedge clk);
        taken = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        tries++;
      end
      if (!taken) check($sformatf("send_timeout_beat%0d", i), taken, 1'b1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "time limit exceeded");
  end

  initial begin
    logic [31:0] snap_log, snap_byp;
    logic [1:0]  snap_zero;
    logic        snap_valid;
    int          start_cnt;

    vecs[0] = '{32'h0001_0100, 16'h0000, 16'hF800, 16'h0000, 16'hF800, 2'b00};
    vecs[1] = '{32'h8000_0200, 16'h0100, 16'h0700, 16'h0100, 16'h0700, 2'b00};
    vecs[2] = '{32'hFFFF_0180, 16'h0080, 16'h07FF, 16'h0080, 16'h0800, 2'b00};
    vecs[3] = '{32'h0300_0000, 16'h8000, 16'h0180, 16'h8000, 16'h0180, 2'b01};
    vecs[4] = '{32'h1FFF_0003, 16'hF980, 16'h04FF, 16'hF980, 16'h0500, 2'b00};
    vecs[5] = '{32'h80FF_8040, 16'h0700, 16'h0701, 16'h0701, 16'h0702, 2'b00};
    vecs[6] = '{32'h0000_0101, 16'h0001, 16'h8000, 16'h0001, 16'h8000, 2'b10};
    vecs[7] = '{32'h0000_FFFF, 16'h07FF, 16'h8000, 16'h0800, 16'h8000, 2'b10};

    rst = 1'b1;
    en = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;

    // Reset state, then in_ready must come up with en high.
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1'b1);

    // Table vectors, one isolated beat each: result appears exactly three edges after acceptance.
    chk_lat = 1'b1;
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[v].din;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", v), bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_not_early", v), bus.out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", v), bus.out_valid, 1'b1);
      check($sformatf("vec%0d_log0", v), bus.out_log[15:0], vecs[v].t0);
      check($sformatf("vec%0d_log1", v), bus.out_log[31:16], vecs[v].t1);
      check($sformatf("vec%0d_rnd_log0", v), bus_r.out_log[15:0], vecs[v].r0);
      check($sformatf("vec%0d_rnd_log1", v), bus_r.out_log[31:16], vecs[v].r1);
      check($sformatf("vec%0d_zero", v), bus.out_zero, vecs[v].zero);
      check($sformatf("vec%0d_bypass", v), bus.out_bypass, vecs[v].din);
    end
    wait_drain(20);
    chk_lat = 1'b0;

    // Backpressure: out_ready low for six cycles while eight beats stream in.
    for (int i = 0; i < 8; i++) stim[i] = {16'(16'h0123 * (i + 1)), 16'(16'h0111 * (i + 1) + 16'h0010)};
    start_cnt = out_cnt;
    @(posedge clk); #1;
    fork
      send_beats(8, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap_log  = bus.out_log;
        snap_byp  = bus.out_bypass;
        snap_zero = bus.out_zero;
        check("stall_out_valid", bus.out_valid, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_low", bus.in_ready, 1'b0);
        check("stall_valid_held", bus.out_valid, 1'b1);
        check("stall_log_held", bus.out_log, snap_log);
        check("stall_bypass_held", bus.out_bypass, snap_byp);
        check("stall_zero_held", bus.out_zero, snap_zero);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain(50);
    check("stall_beat_count", out_cnt - start_cnt, 8);

    // Freeze: en low for four cycles mid-stream.
    for (int i = 0; i < 10; i++) stim[i] = {rand_word(), rand_word()};
    start_cnt = out_cnt;
    @(posedge clk); #1;
    fork
      send_beats(10, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        snap_valid = bus.out_valid;
        snap_log   = bus.out_log;
        snap_byp   = bus.out_bypass;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("freeze_valid_held", bus.out_valid, snap_valid);
        check("freeze_log_held", bus.out_log, snap_log);
        check("freeze_bypass_held", bus.out_bypass, snap_byp);
        @(posedge clk); #1;
        en = 1'b1;
      end
    join
    wait_drain(50);
    check("freeze_beat_count", out_cnt - start_cnt, 10);

    // Reset with three beats in flight: nothing may emerge afterwards.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) stim[i] = {16'(16'h0400 + i), 16'(16'h2000 + i)};
    send_beats(3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    check("midrst_in_ready", bus.in_ready, 1'b1);
    start_cnt = out_cnt;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrst_no_stale_beat", out_cnt - start_cnt, 0);
    check("midrst_valid_low", bus.out_valid, 1'b0);

    // Random traffic with random backpressure, occasional freezes and input gaps.
    for (int i = 0; i < 300; i++) stim[i] = {rand_word(), rand_word()};
    start_cnt = out_cnt;
    rnd_done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        send_beats(300, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 9) < 7);
          en = ($urandom_range(0, 19) != 0);
        end
      end
    join
    en = 1'b1;
    bus.out_ready = 1'b1;
    wait_drain(100);
    check("random_beat_count", out_cnt - start_cnt, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
